// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: multi-cycle data-memory controller between the MEM stage and
// an external 32-bit asynchronous SRAM. Stalls the pipeline while an access
// runs, and returns captured read data held stable through the DONE cycle.
module data_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 18,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ram_chip_enable,
  input  logic                  ram_operation,
  input  logic [31:0]           ram_addr,
  input  logic [3:0]            ram_select_signal,
  input  logic [31:0]           ram_write_data,
  output logic [31:0]           ram_read_data,
  output logic                  stall_request,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n,
  output logic [31:0]           sram_wdata,
  output logic                  sram_wdata_oe,
  input  logic [31:0]           sram_rdata
);

  localparam int unsigned CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] count;
  logic          op_write;
  logic          last_cycle;

  // Byte offset bits and bits above the SRAM window are deliberately dropped
  // (lanes come from ram_select_signal, high bits wrap around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_addr[31:ADDR_WIDTH+2], ram_addr[1:0]};

  assign last_cycle = (count == '0);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and stall decode; DONE ignores the still-asserted old request.
  always_comb begin
    next_state    = state;
    stall_request = 1'b0;
    case (state)
      IDLE: begin
        if (ram_chip_enable) begin
          next_state    = ACCESS;
          stall_request = 1'b1;
        end
      end
      ACCESS: begin
        stall_request = 1'b1;
        if (last_cycle) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (reset) stall_request = 1'b0;
  end

  // Request latch, wait counter, registered strobes and read capture.
  // Strobes are registered so they switch glitch-free with the state change.
  always_ff @(posedge clock) begin
    if (reset) begin
      count         <= '0;
      op_write      <= 1'b0;
      ram_read_data <= '0;
      sram_addr     <= '0;
      sram_be_n     <= '1;
      sram_wdata    <= '0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_wdata_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ram_chip_enable) begin
            op_write      <= ram_operation;
            sram_addr     <= ram_addr[ADDR_WIDTH+1:2];
            sram_be_n     <= ~ram_select_signal;
            sram_wdata    <= ram_write_data;
            count         <= CW'(WAIT_STATES - 1);
            sram_ce_n     <= 1'b0;
            sram_oe_n     <= ram_operation;
            sram_we_n     <= ~ram_operation;
            sram_wdata_oe <= ram_operation;
          end
        end
        ACCESS: begin
          if (last_cycle) begin
            if (!op_write) ram_read_data <= sram_rdata;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_wdata_oe <= 1'b0;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/data_ram_ctrl.md
# data_ram_ctrl

Data-memory controller that sits directly downstream of the MEM stage. It accepts the MEM stage's combinational RAM request (address, read/write, big-endian byte selects, write data, chip enable) and runs a multi-cycle access on an external 32-bit asynchronous SRAM, stalling the pipeline until the access completes. It returns read data to the MEM stage's `input_ram_read_data`, and holds that data stable for the cycle in which the pipeline advances.

## Interface
Parameters:
- `ADDR_WIDTH`, 18, SRAM word-address width.
- `WAIT_STATES`, 2, number of cycles the SRAM strobes stay asserted per access. Legal values are ≥1.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `ram_chip_enable`  in  1  request valid (from MEM).
- `ram_operation`  in  1  0 = read, 1 = write.
- `ram_addr`  in  32  byte address.
- `ram_select_signal`  in  4  byte lanes; bit 3 = data[31:24] = byte offset 0 (big-endian).
- `ram_write_data`  in  32  store data, already lane-replicated by MEM.
- `ram_read_data`  out  32  captured read word, returned to MEM.
- `stall_request`  out  1  pipeline stall request.
- `sram_addr`  out  ADDR_WIDTH  word address.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low strobes.
- `sram_be_n`  out  4  active-low byte enables.
- `sram_wdata`  out  32  write data.
- `sram_wdata_oe`  out  1  data-bus drive enable.
- `sram_rdata`  in  32  SRAM read bus.

## Operation
The FSM has three states:

- **IDLE**
  - Strobes are inactive.
  - If `ram_chip_enable` is high:
    - Latch `ram_operation`, `sram_addr <= ram_addr[ADDR_WIDTH+1:2]`, `sram_be_n <= ~ram_select_signal` and `sram_wdata <= ram_write_data`.
    - Load the wait counter with `WAIT_STATES-1`.
    - Go to ACCESS.
- **ACCESS**
  - `sram_ce_n` is 0.
  - On a read, `sram_oe_n` is 0. On a write, `sram_we_n` is 0 and `sram_wdata_oe` is 1.
  - The counter decrements each cycle.
  - When the counter is 0:
    - On a read, capture `sram_rdata` into `ram_read_data`.
    - Deassert all strobes and `sram_wdata_oe` at the same edge.
    - Go to DONE.
- **DONE**
  - `stall_request` is 0.
  - `ram_chip_enable` is ignored, because it still shows the request that just completed.
  - Next state is IDLE unconditionally.

Signal behaviour:

- `stall_request` is combinational: `!reset && ((IDLE && ram_chip_enable) || ACCESS)`.
- `ram_read_data` changes only on read capture. Writes leave it unchanged.
- `sram_addr`, `sram_be_n` and `sram_wdata` are registered. They change only on an IDLE latch and stay stable through ACCESS and the following cycle.
- Address bits above `ADDR_WIDTH+1` are discarded (wrap-around). Bits [1:0] are ignored; lane selection is carried entirely by `ram_select_signal`.
- A select of 0000 still runs a full-length access with all `sram_be_n` high. A read captures the bus regardless.

## Timing
- Reset value of every output:
  - `ram_read_data` = 0.
  - `stall_request` = 0.
  - `sram_addr` = 0.
  - `sram_ce_n`, `sram_oe_n`, `sram_we_n` = 1.
  - `sram_be_n` = 4'b1111.
  - `sram_wdata` = 0.
  - `sram_wdata_oe` = 0.
  - State = IDLE.
- Cycle-level access, with the request first seen in cycle 0:
  - `stall_request` is high in cycles 0..W, where W = `WAIT_STATES`.
  - Strobes are active in cycles 1..W.
  - Read data is captured at the end of cycle W and is valid from cycle W+1, which is the DONE cycle.
  - The pipeline advances at the end of cycle W+1.
- Total latency is W+2 cycles per access. The earliest next request is seen in cycle W+2.
- Reset mid-ACCESS: the state returns to IDLE and all outputs take their reset values on the next cycle. The access is abandoned and is not retried. A request that is still present after reset deasserts starts a fresh access.

## Test plan
1. **Reset:** hold `reset` for 2 cycles with `ram_chip_enable`=1 → all outputs equal their reset values, no strobe falls, `stall_request`=0.
2. **Read:** W=2, read, addr 0x00000010, sel 1111, `sram_rdata`=0xDEADBEEF →
   - `stall_request` is 1 in cycles 0–2.
   - `sram_addr`=0x00004.
   - `ce_n`/`oe_n` are 0 in cycles 1–2.
   - `ram_read_data`=0xDEADBEEF and `stall_request`=0 in cycle 3.
3. **Byte store:** W=2, write, addr 0x00000013, sel 0001, data 0x5A5A5A5A →
   - `sram_be_n`=1110 and `sram_wdata`=0x5A5A5A5A.
   - `we_n`=0 and `sram_wdata_oe`=1 in cycles 1–2.
   - `ram_read_data` is unchanged.
4. **Back-to-back:** a read request held through DONE, followed by a write presented in cycle 4 →
   - No second access is launched from the DONE cycle.
   - The write's strobes are active in cycles 5–6.
5. **Reset mid-access:** assert `reset` in cycle 1 of a read →
   - Strobes are inactive and `stall_request`=0 in cycle 2.
   - `ram_read_data`=0.
   - After release with the request still present, a fresh access begins, and its strobes assert one cycle after release.
6. **Address wrap:** `ADDR_WIDTH`=18, addr 0xFFFFFFFC, W=1 →
   - `sram_addr`=0x3FFFF.
   - `stall_request` is high for exactly 2 cycles.
